// File: rtl/aix_spram_pkg.sv
// Shared definitions for the scale-SRAM read path: FSM state encoding and
// the address-increment helper that wraps at the RAM depth.
package aix_spram_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_FIN   = 2'd3
  } rd_state_e;

  // Next sequential address; depth-1 wraps to 0 rather than to 2^AW.
  function automatic int unsigned addr_inc_wrap(input int unsigned addr,
                                                input int unsigned depth);
    return (addr >= depth - 1) ? 0 : addr + 1;
  endfunction

endpackage

// File: rtl/sync_fifo_fwft.sv
// First-word-fall-through FIFO: the head entry is visible on rdata whenever
// empty is low. Push and pop may happen in the same cycle, including when full.
module sync_fifo_fwft #(
  parameter int DW         = 128,
  parameter int FIFO_DEPTH = 4,
  localparam int PW        = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1,
  localparam int CW        = $clog2(FIFO_DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          push,
  input  logic [DW-1:0] wdata,
  input  logic          pop,
  output logic [DW-1:0] rdata,
  output logic          empty,
  output logic [CW-1:0] count
);

  logic [DW-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          full;
  logic          wr_en;
  logic          rd_en;

  assign empty = (count == '0);
  assign full  = (count == CW'(FIFO_DEPTH));
  assign rd_en = pop && !empty;
  // A pop in the same cycle frees the slot a full-FIFO push needs.
  assign wr_en = push && (!full || rd_en);
  assign rdata = mem[rd_ptr];

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Storage write and pointer/count bookkeeping.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= ptr_inc(wr_ptr);
      end
      if (rd_en) rd_ptr <= ptr_inc(rd_ptr);
      case ({wr_en, rd_en})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // The upstream credit check must make a push into a full, non-popping FIFO impossible.
  assert property (@(posedge clk) disable iff (!rstn) !(push && full && !rd_en));

endmodule

// File: rtl/spram_scale_reader.sv
// Burst read initiator for the single-port scale SRAM. Issues sequential reads
// (wrapping at DEPTH), tracks in-flight reads through a latency shift register
// and re-times the returned words onto a valid/ready stream with a last marker.
//
// Stream handshake: m_data/m_last are meaningful only while m_valid is high;
// a beat transfers on a rising clk edge where m_valid && m_ready; m_valid,
// m_data and m_last hold steady until that transfer.
module spram_scale_reader
  import aix_spram_pkg::*;
#(
  parameter int DW         = 128,
  parameter int AW         = 4,
  parameter int DEPTH      = 16,
  parameter int RD_LAT     = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          start,
  input  logic [AW-1:0] base_addr,
  input  logic [AW:0]   num_words,
  output logic          busy,
  output logic          done,
  output logic          ram_cs,
  output logic          ram_we,
  output logic [AW-1:0] ram_addr,
  input  logic [DW-1:0] ram_rdata,
  output logic          m_valid,
  output logic [DW-1:0] m_data,
  output logic          m_last,
  input  logic          m_ready,
  output logic [1:0]    dbg_state
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int IW = $clog2(RD_LAT + 1);

  rd_state_e         state_q;
  rd_state_e         state_d;
  logic [AW-1:0]     rd_addr_q;
  logic [AW:0]       issue_cnt_q;
  logic [AW:0]       beat_cnt_q;
  logic [RD_LAT-1:0] vld_sr_q;
  logic [IW-1:0]     inflight;
  logic [CW-1:0]     fifo_count;
  logic [CW:0]       credit_used;
  logic              fifo_empty;
  logic              accept_start;
  logic              issue;
  logic              beat;

  assign accept_start = (state_q == ST_IDLE) && start;

  // Reads already issued but not yet returned still own a FIFO slot.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < RD_LAT; i++) inflight = inflight + IW'(vld_sr_q[i]);
  end

  assign credit_used = (CW+1)'(fifo_count) + (CW+1)'(inflight);
  assign issue = (state_q == ST_RUN) && (issue_cnt_q != '0) &&
                 (credit_used < (CW+1)'(FIFO_DEPTH));
  assign beat  = m_valid && m_ready;

  // State register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start) state_d = (num_words == '0) ? ST_FIN : ST_RUN;
      ST_RUN:   if (issue && (issue_cnt_q == (AW+1)'(1))) state_d = ST_DRAIN;
      ST_DRAIN: if (beat && m_last) state_d = ST_FIN;
      ST_FIN:   state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Read address, issue counter and beat counter.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rd_addr_q   <= '0;
      issue_cnt_q <= '0;
      beat_cnt_q  <= '0;
    end else if (accept_start) begin
      rd_addr_q   <= base_addr;
      issue_cnt_q <= num_words;
      beat_cnt_q  <= num_words;
    end else begin
      if (issue) begin
        rd_addr_q   <= AW'(addr_inc_wrap(32'(rd_addr_q), DEPTH));
        issue_cnt_q <= issue_cnt_q - (AW+1)'(1);
      end
      if (beat) beat_cnt_q <= beat_cnt_q - (AW+1)'(1);
    end
  end

  // Read-latency valid pipeline; its tail marks ram_rdata as a returned word.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      vld_sr_q <= '0;
    end else begin
      vld_sr_q[0] <= issue;
      for (int i = 1; i < RD_LAT; i++) vld_sr_q[i] <= vld_sr_q[i-1];
    end
  end

  sync_fifo_fwft #(
    .DW         (DW),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_out_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .push  (vld_sr_q[RD_LAT-1]),
    .wdata (ram_rdata),
    .pop   (beat),
    .rdata (m_data),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign m_valid   = !fifo_empty;
  assign m_last    = m_valid && (beat_cnt_q == (AW+1)'(1));
  assign busy      = (state_q == ST_RUN) || (state_q == ST_DRAIN);
  assign done      = (state_q == ST_FIN);
  assign ram_cs    = issue;
  assign ram_we    = 1'b0;
  assign ram_addr  = rd_addr_q;
  assign dbg_state = state_q;

endmodule

// File: doc/spram_scale_reader.md
# spram_scale_reader

Read-side initiator for the single-port scale SRAM (16x128 by default). On a start command it issues a burst of sequential reads starting at a base address and wrapping modulo DEPTH. It absorbs the RAM's fixed read latency and re-times the returned words onto a valid/ready stream with a last marker. It sits between the scale SRAM wrapper and the scale/requantization consumer in the layer datapath, and lets that consumer apply backpressure without losing in-flight read data.

## Interface
Parameters:
- DW, 128: data width per word; must match the RAM.
- AW, 4: address width.
- DEPTH, 16: RAM word count; address wrap point.
- RD_LAT, 1: RAM read latency in cycles, from `ram_cs` sampled to `ram_rdata` valid. Unconditional.
- FIFO_DEPTH, 4: output buffer entries; must be ≥ RD_LAT+2.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rstn  in  1  asynchronous active-low reset.
- start  in  1  one-cycle command strobe; ignored while `busy`=1.
- base_addr  in  AW  first read address; sampled with `start`.
- num_words  in  AW+1  burst length, 0..DEPTH; sampled with `start`.
- busy  out  1  burst in progress.
- done  out  1  one-cycle pulse at burst completion.
- ram_cs  out  1  RAM chip-select.
- ram_we  out  1  RAM write enable; constant 0.
- ram_addr  out  AW  RAM address.
- ram_rdata  in  DW  RAM read data.
- m_valid  out  1  output word valid.
- m_data  out  DW  output word.
- m_last  out  1  qualifies the final word of the burst.
- m_ready  in  1  consumer accept.

## Operation
- FSM states: IDLE, RUN, DRAIN, FIN.
- IDLE → RUN on `start`:
  - latch `base_addr` into the read address.
  - latch `num_words` into the issue counter and the beat counter.
  - If `num_words`=0, go IDLE → FIN instead; no RAM access.
- RUN: issue one read per cycle (`ram_cs`=1, `ram_addr`=current address) whenever issue count > 0 and fifo_count + inflight < FIFO_DEPTH.
  - Each issue advances the address: increment; DEPTH-1 wraps to 0, not to 2^AW.
  - Each issue decrements the issue count.
  - RUN → DRAIN when the last read has issued.
- Inflight tracking: a RD_LAT-deep valid shift register; its tail writes `ram_rdata` into the FIFO.
  - inflight = popcount of that register.
- Output: `m_valid` = FIFO not empty; `m_data` = FIFO head.
  - A beat transfers when `m_valid` & `m_ready`; it pops the FIFO and decrements the beat counter.
  - `m_last` = `m_valid` & (beat counter == 1).
- DRAIN → FIN when the beat with `m_last` transfers.
- FIN: `done`=1 for one cycle, then → IDLE.
- `busy` = 1 in RUN and DRAIN; 0 in IDLE and FIN.
- `ram_cs` = 0 outside RUN; `ram_addr` holds its last value when idle.
- FIFO never overflows; the credit check guarantees it. An overflow is an assertion failure.
- FIFO push and pop in the same cycle leave the count unchanged; this is legal when full or empty-with-bypass-not-required.
- Reset (any time, including mid-burst):
  - all counters, the valid shift register and the FIFO clear; state returns to IDLE.
  - in-flight RAM data is discarded.

## Timing
- Reset values: `busy`=0, `done`=0, `ram_cs`=0, `ram_we`=0, `ram_addr`=0, `m_valid`=0, `m_last`=0, `m_data`=0.
- `start` sampled in cycle 0 → first `ram_cs` in cycle 1 → first `m_valid` in cycle 2+RD_LAT.
- Throughput: one word per cycle with `m_ready` held high.
- Backpressure:
  - issue stalls within one cycle once the credit limit is reached.
  - issue resumes the cycle after a pop frees a credit.
- Last beat accepted in cycle T → `done`=1 and `busy`=0 in cycle T+1.
- A `start` in the cycle after FIN is accepted.
- A `start` coincident with FIN is ignored.
- `num_words`=0: `start` in cycle 0 → `done` in cycle 1; no `m_valid`.

## Structure
- Shared package `aix_spram_pkg`: FSM state encoding (IDLE=0, RUN=1, DRAIN=2, FIN=3) and an address-increment-with-wrap function parameterized by DEPTH.
- Sub-module `sync_fifo_fwft` (first-word-fall-through, parameters DW and FIFO_DEPTH, async active-low reset, count output) is instantiated for the output buffer.
- Credit logic, latency shift register and FSM stay in the top module.

## Test plan
- Basic burst: RAM preloaded with word i = i, `base_addr`=0, `num_words`=16, `m_ready`=1 → data 0..15 on consecutive cycles, first `m_valid` in cycle 3, `m_last` on 15, `done` one cycle after.
- Wrap: `base_addr`=14, `num_words`=4 → addresses 14, 15, 0, 1; data 14, 15, 0, 1.
- Backpressure: `num_words`=8, `m_ready` toggling 1,0,0,1,… → all 8 words delivered in order, none lost or duplicated, inflight+fifo_count ≤ 4 every cycle.
- Zero length: `num_words`=0 → `done` in cycle 1, `ram_cs` never high, `m_valid` never high.
- Start while busy: second `start` with `base_addr`=5 mid-burst → ignored, original burst completes unchanged.
- Reset mid-burst: `rstn` low for 1 cycle after 3 beats → all outputs at reset values immediately; a new burst then returns correct data from its own base address.
